// File: rtl/elapsed_timer.sv
// Stopwatch counting MM:SS in BCD with start/stop/clear control and an optional limit.
// Optional lap capture is enabled by defining ELAPSED_TIMER_LAP_EN.
module elapsed_timer #(
  parameter int unsigned TICK_DIV = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  input  logic [15:0] limit_bcd,
  output logic [15:0] digits,
  output logic        running,
  output logic        sec_pulse,
  output logic        wrap,
  output logic        limit_hit,
  output logic [15:0] lap_bcd
);

  localparam int PW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [15:0]   digits_s, inc_s, lap_s;
  logic          pulse_s, wrap_s;

  function automatic logic [15:0] bcd_inc(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (d[3:0] != 4'd9) begin
      r[3:0] = d[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (d[7:4] != 4'd5) begin
        r[7:4] = d[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (d[11:8] != 4'd9) begin
          r[11:8] = d[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          if (d[15:12] != 4'd9) begin
            r[15:12] = d[15:12] + 4'd1;
          end else begin
            r[15:12] = 4'd0;
          end
        end
      end
    end
    return r;
  endfunction

  // A zero limit disables the stop; malformed BCD can never be reached so it never matches.
  function automatic logic limit_valid(input logic [15:0] l);
    return (l != 16'h0000) && (l[15:12] <= 4'd9) && (l[11:8] <= 4'd9) &&
           (l[7:4] <= 4'd5) && (l[3:0] <= 4'd9);
  endfunction

`ifndef ELAPSED_TIMER_LAP_EN
  logic unused_lap_s;
  assign unused_lap_s = lap;
`endif

  // Next-state, prescaler, count and lap logic; stop outranks start when both are asserted.
  always_comb begin
    state_s  = state_r;
    presc_s  = presc_r;
    digits_s = digits;
    pulse_s  = 1'b0;
    wrap_s   = 1'b0;
    lap_s    = lap_bcd;
    inc_s    = bcd_inc(digits);
    if (clear) begin
      state_s  = IDLE;
      presc_s  = '0;
      digits_s = 16'h0000;
      lap_s    = 16'h0000;
    end else begin
`ifdef ELAPSED_TIMER_LAP_EN
      if (lap && (state_r != IDLE)) begin
        lap_s = digits;
      end else begin
        lap_s = lap_bcd;
      end
`else
      lap_s = 16'h0000;
`endif
      case (state_r)
        IDLE, PAUSE: begin
          if (start && !stop) begin
            state_s = RUN;
          end else begin
            state_s = state_r;
          end
        end
        RUN: begin
          if (stop) begin
            state_s = PAUSE;
          end else if (presc_r == TERM) begin
            presc_s  = '0;
            digits_s = inc_s;
            pulse_s  = 1'b1;
            wrap_s   = (inc_s == 16'h0000);
            if (limit_valid(limit_bcd) && (inc_s == limit_bcd)) begin
              state_s = DONE;
            end else begin
              state_s = RUN;
            end
          end else begin
            presc_s = presc_r + PW'(1);
          end
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      presc_r   <= '0;
      digits    <= 16'h0000;
      running   <= 1'b0;
      sec_pulse <= 1'b0;
      wrap      <= 1'b0;
      limit_hit <= 1'b0;
      lap_bcd   <= 16'h0000;
    end else begin
      state_r   <= state_s;
      presc_r   <= presc_s;
      digits    <= digits_s;
      running   <= (state_s == RUN);
      sec_pulse <= pulse_s;
      wrap      <= wrap_s;
      limit_hit <= (state_s == DONE);
      lap_bcd   <= lap_s;
    end
  end

endmodule

// File: tb/tb_elapsed_timer.sv
// Self-checking bench for elapsed_timer (TICK_DIV=4): directed table, corner sequences,
// and randomized traffic against a seconds-based reference model.
module tb_elapsed_timer;

  localparam int TD = 4;
`ifdef ELAPSED_TIMER_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] limit_bcd = 16'h0000;
  logic [15:0] digits, lap_bcd;
  logic        running, sec_pulse, wrap, limit_hit;

  int tests = 0;
  int fails = 0;

  elapsed_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .limit_bcd(limit_bcd), .digits(digits), .running(running), .sec_pulse(sec_pulse),
    .wrap(wrap), .limit_hit(limit_hit), .lap_bcd(lap_bcd)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed time as whole seconds, mode as small integer.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int          m_secs, m_ticks, m_mode;
  bit          m_pulse, m_wrap;
  logic [15:0] m_lap;

  function automatic logic [15:0] to_bcd(input int s);
    int m, c;
    m = s / 60;
    c = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_ticks = 0; m_mode = M_IDLE; m_pulse = 1'b0; m_wrap = 1'b0; m_lap = 16'h0000;
  endtask

  task automatic model_step(input logic s, input logic sp, input logic c, input logic l,
                            input logic [15:0] lim);
    bit lok;
    int lsec;
    m_pulse = 1'b0;
    m_wrap  = 1'b0;
    lok  = (lim != 16'h0000) && (lim[15:12] <= 4'd9) && (lim[11:8] <= 4'd9) &&
           (lim[7:4] <= 4'd5) && (lim[3:0] <= 4'd9);
    lsec = (10 * int'(lim[15:12]) + int'(lim[11:8])) * 60 + 10 * int'(lim[7:4]) + int'(lim[3:0]);
    if (c) begin
      m_mode = M_IDLE; m_ticks = 0; m_secs = 0; m_lap = 16'h0000;
    end else begin
      if (LAP_EN && l && m_mode != M_IDLE) m_lap = to_bcd(m_secs);
      if (m_mode == M_RUN) begin
        if (sp) m_mode = M_PAUSE;
        else if (m_ticks == TD - 1) begin
          m_ticks = 0;
          m_secs  = (m_secs + 1) % 6000;
          m_pulse = 1'b1;
          m_wrap  = (m_secs == 0);
          if (lok && m_secs == lsec) m_mode = M_DONE;
        end else m_ticks++;
      end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && s && !sp) m_mode = M_RUN;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [35:0] act, exp;
    act = {digits, running, sec_pulse, wrap, limit_hit, lap_bcd};
    exp = {to_bcd(m_secs), (m_mode == M_RUN), m_pulse, m_wrap, (m_mode == M_DONE), m_lap};
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL model t=%0t: got dig=%h run=%b sp=%b wr=%b hit=%b lap=%h expected dig=%h run=%b sp=%b wr=%b hit=%b lap=%h",
                 $time, act[35:20], act[19], act[18], act[17], act[16], act[15:0],
                 exp[35:20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // One clock: drive at negedge, model steps at posedge, compare at next negedge.
  task automatic cycle(input logic s, input logic sp, input logic c, input logic l,
                       input logic [15:0] lim);
    start = s; stop = sp; clear = c; lap = l; limit_bcd = lim;
    @(posedge clk);
    model_step(s, sp, c, l, lim);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n, input logic [15:0] lim);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, lim);
  endtask

  typedef struct {
    logic        s, sp, c;
    logic        e_run;
    logic [15:0] e_dig;
    logic        e_pulse;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic sp, input logic c,
                              input logic er, input logic [15:0] ed, input logic ep);
    vec_t v;
    v.s = s; v.sp = sp; v.c = c; v.e_run = er; v.e_dig = ed; v.e_pulse = ep;
    return v;
  endfunction

  initial begin
    logic [15:0] lims [7];
    logic [15:0] lim;
    lims[0] = 16'h0000; lims[1] = 16'h0005; lims[2] = 16'h000A; lims[3] = 16'h0060;
    lims[4] = 16'h0012; lims[5] = 16'h0100; lims[6] = 16'h0007;

    // Start, two increments, stop two cycles after an increment, resume, then terminal-cycle stop.
    vecs.push_back(mk(1, 0, 0, 1, 16'h0000, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0001, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 1, 16'h0001, 0));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0002, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0002, 0));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0002, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0002, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 0, 0, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0002, 0));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0002, 0));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0003, 1));
    vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0000, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0001, 1));

    // Reset state.
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_digits", digits, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'h0000);
    chk("rst_hit", {15'd0, limit_hit}, 16'h0000);
    chk("rst_lap", lap_bcd, 16'h0000);
    rst = 1'b1;
    idle(2, 16'h0000);

    // Directed table.
    foreach (vecs[i]) begin
      cycle(vecs[i].s, vecs[i].sp, vecs[i].c, 1'b0, 16'h0000);
      chk($sformatf("vec%0d_run", i), {15'd0, running}, {15'd0, vecs[i].e_run});
      chk($sformatf("vec%0d_dig", i), digits, vecs[i].e_dig);
      chk($sformatf("vec%0d_pulse", i), {15'd0, sec_pulse}, {15'd0, vecs[i].e_pulse});
    end

    // Limit stop at 00:03, start ignored in DONE, clear leaves DONE.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0003);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003);
    idle(12, 16'h0003);
    chk("lim_dig", digits, 16'h0003);
    chk("lim_hit", {15'd0, limit_hit}, 16'h0001);
    chk("lim_run", {15'd0, running}, 16'h0000);
    idle(5, 16'h0003);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003);
    chk("done_start_ign", {digits, 7'd0, running, limit_hit}, {16'h0003, 7'd0, 1'b0, 1'b1});
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0003);
    chk("done_clear", {digits, 7'd0, running, limit_hit}, {16'h0000, 7'd0, 1'b0, 1'b0});

    // Carry chain and full wrap.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle(40, 16'h0000);
    chk("carry_0010", digits, 16'h0010);
    idle(200, 16'h0000);
    chk("carry_0100", digits, 16'h0100);
    idle(5999 * TD - 240, 16'h0000);
    chk("at_9959", digits, 16'h9959);
    idle(TD, 16'h0000);
    chk("wrap_dig", digits, 16'h0000);
    chk("wrap_hi", {15'd0, wrap}, 16'h0001);
    idle(1, 16'h0000);
    chk("wrap_lo", {15'd0, wrap}, 16'h0000);

    // Asynchronous reset mid-run at 00:05.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle(20, 16'h0000);
    chk("pre_rst_0005", digits, 16'h0005);
    #2 rst = 1'b0;
    #1;
    chk("arst_outs", {digits, 2'd0, running, sec_pulse, wrap, limit_hit}, 22'd0);
    chk("arst_lap", lap_bcd, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(10, 16'h0000);
    chk("post_rst_idle", {digits, 15'd0, running}, 32'd0);

    // Lap capture, including a lap coinciding with an increment.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle(8, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("lap_0002", lap_bcd, LAP_EN ? 16'h0002 : 16'h0000);
    idle(6, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("lap_inc_dig", digits, 16'h0004);
    chk("lap_inc_lap", lap_bcd, LAP_EN ? 16'h0003 : 16'h0000);

    // Randomized traffic.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    lim = 16'h0000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0)
        lim = ($urandom_range(0, 7) == 7) ? 16'($urandom) : lims[$urandom_range(0, 6)];
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0, lim);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elapsed_timer.md
ELAPSED_TIMER -- requirements
Module: elapsed_timer

Interface
REQ-001: Parameter TICK_DIV, default 50000000, clk cycles per count increment (>=2).
REQ-002: clk  input  1  rising-edge system clock.
REQ-003: rst  input  1  asynchronous, active-low reset.
REQ-004: start  input  1  one-cycle request to begin or resume counting.
REQ-005: stop  input  1  one-cycle request to pause counting.
REQ-006: clear  input  1  one-cycle request to zero the count and return to idle.
REQ-007: limit_bcd  input  16  stop value {min tens, min units, sec tens, sec units}; 16'h0000 = no limit.
REQ-008: digits  output  16  current count, same BCD packing as limit_bcd.
REQ-009: running  output  1  high while in RUN.
REQ-010: sec_pulse  output  1  one-cycle strobe, high in the cycle digits first shows an incremented value.
REQ-011: wrap  output  1  one-cycle strobe coincident with sec_pulse when the count rolls 99:59 -> 00:00.
REQ-012: limit_hit  output  1  sticky, high in DONE.
REQ-013: lap  input  1  lap-capture strobe.
REQ-014: lap_bcd  output  16  captured count.

Function
REQ-015: States IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-016: Same-cycle input priority is clear > stop > start.
REQ-017: clear in any state: next cycle IDLE, digits 0, prescaler 0, limit_hit 0, lap_bcd 0.
REQ-018: start in IDLE or PAUSE: next cycle RUN, running 1; start in RUN or DONE is ignored.
REQ-019: stop in RUN: next cycle PAUSE, running 0, prescaler and digits held; stop elsewhere ignored.
REQ-020: Prescaler counts 0..TICK_DIV-1 only in RUN, starting from its held value; at TICK_DIV-1 it returns to 0 and the count increments next cycle.
REQ-021: First increment after start from IDLE appears exactly TICK_DIV cycles after running rises.
REQ-022: Increment: sec units 0-9, carry to sec tens 0-5, carry to min units 0-9, carry to min tens 0-9; 99:59 wraps to 00:00 with wrap=1.
REQ-023: If the incremented count equals a nonzero limit_bcd, next state DONE, running 0, limit_hit 1, digits frozen at the limit.
REQ-024: limit_bcd is sampled every cycle; a limit already passed, or containing an invalid BCD digit (unit >9, sec tens >5), never matches and counting continues.
REQ-025: A stop coinciding with the prescaler terminal cycle suppresses that increment.
REQ-026: DONE exits only via clear or reset.

Reset
REQ-027: rst low asynchronously forces IDLE, prescaler 0, digits 0, running 0, sec_pulse 0, wrap 0, limit_hit 0, lap_bcd 0.
REQ-028: Release of rst takes effect on the next clk edge; reset mid-count discards all progress.

Configuration
REQ-029: Macro ELAPSED_TIMER_LAP_EN defined: lap in RUN, PAUSE or DONE loads lap_bcd with the current digits value on the next edge; if an increment coincides, lap_bcd gets the pre-increment value.
REQ-030: Lap in IDLE is ignored; clear has priority over lap.
REQ-031: Macro ELAPSED_TIMER_LAP_EN undefined: lap is ignored and lap_bcd is constant 0; ports remain present.

Verification (TICK_DIV=4)
REQ-032: reset, start pulse -> running 1 next cycle; digits 16'h0001 with sec_pulse 4 cycles later; 16'h0002 after 4 more.
REQ-033: Run from 00:09, and separately from 00:59 -> 00:10, then 01:00; from 99:59 -> 00:00 with wrap=1 for one cycle.
REQ-034: limit_bcd=16'h0003, start -> DONE at 00:03, limit_hit 1, running 0; start ignored; clear -> digits 0, limit_hit 0.
REQ-035: Stop 2 cycles after an increment, wait 10 cycles, start -> next increment exactly 2 cycles after running rises; start+stop+clear in the same cycle -> IDLE, digits 0.
REQ-036: rst low mid-RUN at 00:05, asynchronously between edges -> all outputs 0 immediately; no increment after release until start.
REQ-037: With ELAPSED_TIMER_LAP_EN, lap at 00:02 -> lap_bcd 16'h0002 while digits advance; without it, lap_bcd stays 0.
